nes_cpu_bus: RTL and testbench

//  Responder side of the cpu6502 memory bus. Decodes adr/we/dout from the CPU and returns read data on din.

---
 rtl/nes_cpu_bus.sv | 139 +++++++++++++
 tb/tb_nes_cpu_bus.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nes_cpu_bus.sv
// NES CPU-side bus responder: WRAM, PPU register strobes, PRG ROM port and OAM DMA.
module nes_cpu_bus #(
    parameter int unsigned PRG_AW  = 15,
    parameter int unsigned WRAM_AW = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       adr,
    input  logic              we,
    input  logic [7:0]        dout,
    output logic [7:0]        din,
    output logic              rdy,
    output logic [PRG_AW-1:0] prg_adr,
    input  logic [7:0]        prg_data,
    output logic              ppu_cs,
    output logic [2:0]        ppu_a,
    output logic              ppu_we,
    output logic [7:0]        ppu_wdata,
    input  logic [7:0]        ppu_rdata
);

    localparam int unsigned WRAM_DEPTH = 2 ** WRAM_AW;
    localparam logic [15:0] DMA_TRIG   = 16'h4014;
    localparam logic [15:0] OAM_DATA   = 16'h2004;

    typedef enum logic [1:0] {IDLE, ALIGN, READ, WRITE} state_t;

    state_t      state, state_nxt;
    logic        parity;
    logic        align_wait;
    logic [7:0]  page;
    logic [7:0]  index;
    logic [7:0]  wram [WRAM_DEPTH];

    logic [15:0] bus_adr;
    logic        bus_we;
    logic        bus_act;
    logic [7:0]  bus_wdata;
    logic        is_wram, is_ppu, is_rom, is_trig;
    logic        trigger;
    logic [7:0]  rd_data;

    // Bus master mux: CPU in IDLE, DMA engine otherwise; ALIGN makes no access.
    always_comb begin
        bus_adr   = adr;
        bus_we    = we;
        bus_wdata = dout;
        bus_act   = 1'b1;
        case (state)
            ALIGN: begin
                bus_act = 1'b0;
                bus_we  = 1'b0;
            end
            READ: begin
                bus_adr = {page, index};
                bus_we  = 1'b0;
            end
            WRITE: begin
                bus_adr   = OAM_DATA;
                bus_we    = 1'b1;
                bus_wdata = din;
            end
            default: ;
        endcase
    end

    // Address decode and read-data select; unmapped reads return din (open bus).
    always_comb begin
        is_wram = (bus_adr[15:13] == 3'b000);
        is_ppu  = (bus_adr[15:13] == 3'b001);
        is_rom  = bus_adr[15];
        is_trig = (bus_adr == DMA_TRIG);
        trigger = (state == IDLE) && bus_we && is_trig;
        if (is_wram)     rd_data = wram[bus_adr[WRAM_AW-1:0]];
        else if (is_ppu) rd_data = ppu_rdata;
        else if (is_rom) rd_data = prg_data;
        else             rd_data = din;
    end

    // Strobes to PPU and ROM, combinational from the current bus cycle.
    always_comb begin
        prg_adr   = bus_adr[PRG_AW-1:0];
        ppu_cs    = !reset && bus_act && is_ppu;
        ppu_a     = bus_adr[2:0];
        ppu_we    = ppu_cs && bus_we;
        ppu_wdata = bus_wdata;
    end

    // DMA state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // DMA next-state logic; ALIGN lasts one extra cycle when triggered on an odd cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = ALIGN;
            ALIGN:   if (!align_wait) state_nxt = READ;
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = (index == 8'hFF) ? IDLE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: parity, DMA page/index, rdy and the read-data register (also the DMA latch).
    always_ff @(posedge clk) begin
        if (reset) begin
            parity     <= 1'b0;
            align_wait <= 1'b0;
            page       <= 8'h00;
            index      <= 8'h00;
            rdy        <= 1'b1;
            din        <= 8'h00;
        end else begin
            parity <= ~parity;
            if (trigger) begin
                page       <= dout;
                index      <= 8'h00;
                rdy        <= 1'b0;
                align_wait <= parity;
            end
            if (state == ALIGN) align_wait <= 1'b0;
            if (state == WRITE) begin
                index <= index + 8'd1;
                if (index == 8'hFF) rdy <= 1'b1;
            end
            if (bus_act && !bus_we) din <= rd_data;
        end
    end

    // WRAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && bus_act && bus_we && is_wram)
            wram[bus_adr[WRAM_AW-1:0]] <= bus_wdata;
    end

endmodule

// File: tb/tb_nes_cpu_bus.sv
// Directed self-checking bench for nes_cpu_bus.
module tb_nes_cpu_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] adr;
    logic        we;
    logic [7:0]  dout;
    logic [7:0]  din;
    logic        rdy;
    logic [14:0] prg_adr;
    logic [7:0]  prg_data;
    logic        ppu_cs;
    logic [2:0]  ppu_a;
    logic        ppu_we;
    logic [7:0]  ppu_wdata;
    logic [7:0]  ppu_rdata;

    int checks = 0;
    int errors = 0;
    logic par_m;

    nes_cpu_bus #(.PRG_AW(15), .WRAM_AW(11)) dut (
        .clk(clk), .reset(reset), .adr(adr), .we(we), .dout(dout),
        .din(din), .rdy(rdy), .prg_adr(prg_adr), .prg_data(prg_data),
        .ppu_cs(ppu_cs), .ppu_a(ppu_a), .ppu_we(ppu_we),
        .ppu_wdata(ppu_wdata), .ppu_rdata(ppu_rdata)
    );

    always #5 clk = ~clk;

    // ROM model: $0F at $0051, other addresses a simple pattern.
    assign prg_data = (prg_adr == 15'h0051) ? 8'h0F : (prg_adr[7:0] ^ 8'h3C);

    // Expected cycle parity: 0 on the first cycle after reset, toggling each clock.
    always @(posedge clk) par_m <= reset ? 1'b0 : ~par_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        adr = 16'h4000;
        we  = 1'b0;
        dout = 8'h00;
    endtask

    // Trigger a DMA on page $02 on the requested parity and check the whole transfer.
    task automatic run_dma(input logic odd, input int exp_len, input string tag);
        int low;
        int nw;
        int guard;
        low = 0;
        nw = 0;
        guard = 0;
        if (par_m != odd) tick();
        adr = 16'h4014; we = 1'b1; dout = 8'h02;
        tick();
        cpu_idle();
        #1;
        while (guard < 700) begin
            if (!rdy) low++;
            if (ppu_cs) begin
                chk({tag, "_we"}, 32'(ppu_we), 32'd1);
                chk({tag, "_a"}, 32'(ppu_a), 32'd4);
                chk({tag, "_data"}, 32'(ppu_wdata), 32'(8'(nw) ^ 8'hA5));
                nw++;
            end
            if (rdy && low > 0) break;
            tick();
            guard++;
        end
        chk({tag, "_timeout"}, 32'(guard < 700), 32'd1);
        chk({tag, "_len"}, 32'(low), 32'(exp_len));
        chk({tag, "_writes"}, 32'(nw), 32'd256);
    endtask

    initial begin
        int spurious;
        reset = 1'b1;
        ppu_rdata = 8'h00;
        cpu_idle();

        // Reset held two cycles, then released.
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_din", 32'(din), 32'h00);
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_ppu_cs", 32'(ppu_cs), 32'd0);
        tick();

        // WRAM write and mirrored reads.
        adr = 16'h0123; we = 1'b1; dout = 8'h5A;
        tick();
        chk("wram_wr_din", 32'(din), 32'h00);
        adr = 16'h0923; we = 1'b0;
        tick();
        chk("wram_mirror_0923", 32'(din), 32'h5A);
        adr = 16'h1923;
        tick();
        chk("wram_mirror_1923", 32'(din), 32'h5A);

        // ROM read, ignored ROM write, open-bus unmapped read.
        adr = 16'h8051; we = 1'b0;
        #1;
        chk("rom_prg_adr", 32'(prg_adr), 32'h0051);
        tick();
        chk("rom_din", 32'(din), 32'h0F);
        adr = 16'h8000; we = 1'b1; dout = 8'hFF;
        tick();
        chk("rom_wr_din", 32'(din), 32'h0F);
        adr = 16'h5000; we = 1'b0;
        tick();
        chk("open_bus", 32'(din), 32'h0F);

        // PPU register write through a mirror, then a register read.
        adr = 16'h3FFE; we = 1'b1; dout = 8'h21;
        #1;
        chk("ppu_wr_cs", 32'(ppu_cs), 32'd1);
        chk("ppu_wr_a", 32'(ppu_a), 32'd6);
        chk("ppu_wr_we", 32'(ppu_we), 32'd1);
        chk("ppu_wr_data", 32'(ppu_wdata), 32'h21);
        tick();
        cpu_idle();
        #1;
        chk("ppu_cs_drop", 32'(ppu_cs), 32'd0);
        adr = 16'h2002; ppu_rdata = 8'h80;
        #1;
        chk("ppu_rd_cs", 32'(ppu_cs), 32'd1);
        chk("ppu_rd_we", 32'(ppu_we), 32'd0);
        tick();
        chk("ppu_rd_din", 32'(din), 32'h80);
        ppu_rdata = 8'h00;
        cpu_idle();

        // Fill the DMA source page.
        for (int i = 0; i < 256; i++) begin
            adr = 16'(16'h0200 + i); we = 1'b1; dout = 8'(i) ^ 8'hA5;
            tick();
        end
        cpu_idle();
        tick();

        run_dma(1'b0, 513, "dma_even");
        tick();
        run_dma(1'b1, 514, "dma_odd");
        tick();

        // Reset in the middle of a transfer.
        if (par_m) tick();
        adr = 16'h4014; we = 1'b1; dout = 8'h02;
        tick();
        cpu_idle();
        for (int i = 0; i < 100; i++) tick();
        chk("mid_rdy_low", 32'(rdy), 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_cs", 32'(ppu_cs), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(rdy), 32'd1);
        spurious = 0;
        for (int i = 0; i < 600; i++) begin
            if (ppu_cs || !rdy) spurious++;
            tick();
        end
        chk("mid_rst_quiet", 32'(spurious), 32'd0);
        run_dma(1'b0, 513, "dma_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
